// File: rtl/reg_access_pkg.sv
// Shared definitions for the register-access controller.
//   state_t    : controller FSM states
//   WAIT_CNT_W : width of the wait-state counter (WAIT_CYC up to 15)
//   WR / RD    : encodings of the wr_rd_s request bit
package reg_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Configuration-master handshake bundle.
//   sel_en  : request, held by the master until ack is seen
//   wr_rd_s : 1 = write, 0 = read
//   addr    : register index
//   wr_data : write data
//   rd_data : read data returned with ack
//   ack     : single-cycle response pulse
//   err     : error flag, valid with ack
interface reg_access_ctrl_if #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned W_WIDTH = 8
);

  logic               sel_en;
  logic               wr_rd_s;
  logic [A_WIDTH-1:0] addr;
  logic [W_WIDTH-1:0] wr_data;
  logic [W_WIDTH-1:0] rd_data;
  logic               ack;
  logic               err;

  modport master (
    output sel_en, wr_rd_s, addr, wr_data,
    input  rd_data, ack, err
  );

  modport slave (
    input  sel_en, wr_rd_s, addr, wr_data,
    output rd_data, ack, err
  );

endinterface

// File: rtl/reg_addr_decode.sv
// Combinational address decode for the register-access controller.
//   addr    : request address (full A_WIDTH compare, never truncated)
//   wr_rd_s : request direction
//   sel_vec : one-hot hit vector, all zero when addr is out of range
//   wr_vec  : one-hot write strobe vector, zero on read or error
//   err_c   : out-of-range address, or write to a read-only register
module reg_addr_decode
  import reg_access_pkg::*;
#(
  parameter int unsigned           NUM_OF_REG = 4,
  parameter int unsigned           A_WIDTH    = 8,
  parameter logic [NUM_OF_REG-1:0] RO_MASK    = '0
) (
  input  logic [A_WIDTH-1:0]    addr,
  input  logic                  wr_rd_s,
  output logic [NUM_OF_REG-1:0] sel_vec,
  output logic [NUM_OF_REG-1:0] wr_vec,
  output logic                  err_c
);

  logic ro_hit;

  // Each register index is widened to A_WIDTH and compared against the
  // whole address, so high address bits can never alias onto a register.
  always_comb begin
    sel_vec = '0;
    ro_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_OF_REG; i++) begin
      if (addr == A_WIDTH'(i)) begin
        sel_vec[i] = 1'b1;
        ro_hit     = RO_MASK[i];
      end
    end
    err_c  = (sel_vec == '0) || ((wr_rd_s == WR) && ro_hit);
    wr_vec = ((wr_rd_s == RD) || err_c) ? '0 : sel_vec;
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Parametrised register-access controller: one registered read or write of
// a per-port register per sel_en assertion, with optional wait states and
// an error response.
//   clk, rst_n  : clock (posedge) and asynchronous active-low reset
//   bus         : master handshake (sel_en/wr_rd_s/addr/wr_data in,
//                 rd_data/ack/err out)
//   reg_data_in : register i at bits [i*W_WIDTH +: W_WIDTH]
//   wr_en       : one-hot write strobe, one cycle, coincident with ack
//   wr_data_out : captured write data, valid with wr_en, held until the
//                 next successful write
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int unsigned           NUM_OF_REG = 4,
  parameter int unsigned           W_WIDTH    = 8,
  parameter int unsigned           A_WIDTH    = 8,
  parameter logic [NUM_OF_REG-1:0] RO_MASK    = '0,
  parameter int unsigned           WAIT_CYC   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  reg_access_ctrl_if.slave                 bus,
  input  logic [NUM_OF_REG*W_WIDTH-1:0]    reg_data_in,
  output logic [NUM_OF_REG-1:0]            wr_en,
  output logic [W_WIDTH-1:0]               wr_data_out
);

  state_t state_q, state_d;

  logic [WAIT_CNT_W-1:0] cnt_q;

  logic [A_WIDTH-1:0] req_addr_q;
  logic               req_wr_q;
  logic [W_WIDTH-1:0] req_data_q;

  logic [A_WIDTH-1:0]    dec_addr;
  logic                  dec_wr;
  logic [W_WIDTH-1:0]    dec_data;
  logic [NUM_OF_REG-1:0] sel_vec;
  logic [NUM_OF_REG-1:0] wr_vec;
  logic                  err_c;
  logic [W_WIDTH-1:0]    rd_sel;

  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [W_WIDTH-1:0]    rd_q, rd_d;
  logic [NUM_OF_REG-1:0] wr_en_q, wr_en_d;
  logic [W_WIDTH-1:0]    wdo_q, wdo_d;

  // With no wait states RESP is entered on the same edge that captures the
  // request, so the decode has to look at the live bus while in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      dec_addr = bus.addr;
      dec_wr   = bus.wr_rd_s;
      dec_data = bus.wr_data;
    end else begin
      dec_addr = req_addr_q;
      dec_wr   = req_wr_q;
      dec_data = req_data_q;
    end
  end

  reg_addr_decode #(
    .NUM_OF_REG (NUM_OF_REG),
    .A_WIDTH    (A_WIDTH),
    .RO_MASK    (RO_MASK)
  ) u_decode (
    .addr    (dec_addr),
    .wr_rd_s (dec_wr),
    .sel_vec (sel_vec),
    .wr_vec  (wr_vec),
    .err_c   (err_c)
  );

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_OF_REG; i++) begin
      if (sel_vec[i]) begin
        rd_sel = reg_data_in[i*W_WIDTH +: W_WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.sel_en) begin
          state_d = (WAIT_CYC == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.sel_en) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = bus.sel_en ? HOLD : IDLE;
      end
      HOLD: begin
        if (!bus.sel_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    ack_d   = 1'b0;
    wr_en_d = '0;
    err_d   = err_q;
    rd_d    = rd_q;
    wdo_d   = wdo_q;
    if ((state_d == RESP) && (state_q != RESP)) begin
      ack_d   = 1'b1;
      err_d   = err_c;
      wr_en_d = wr_vec;
      rd_d    = (!err_c && (dec_wr == RD)) ? rd_sel : '0;
      if (!err_c && (dec_wr == WR)) begin
        wdo_d = dec_data;
      end
    end else if (state_d == IDLE) begin
      err_d = 1'b0;
      rd_d  = '0;
    end
  end

  // Request capture, wait counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
      req_data_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      wr_en_q    <= '0;
      wdo_q      <= '0;
    end else begin
      if ((state_q == IDLE) && bus.sel_en) begin
        req_addr_q <= bus.addr;
        req_wr_q   <= bus.wr_rd_s;
        req_data_q <= bus.wr_data;
        cnt_q      <= WAIT_CNT_W'(WAIT_CYC);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_en_q <= wr_en_d;
      wdo_q   <= wdo_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.rd_data = rd_q;
  assign wr_en       = wr_en_q;
  assign wr_data_out = wdo_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl: dut 0 has two wait states, dut 1
// none; both have register 3 read-only.
module tb_reg_access_ctrl;

  typedef struct {
    int         edge_n;
    logic [3:0] we;
    logic [7:0] wdo;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel_en = 1'b0;
  logic        wr_rd_s = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  wr_data = '0;
  logic        use_b = 1'b0;
  logic [31:0] reg_data = {8'hD4, 8'h96, 8'h3C, 8'h11};

  int   ecount = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[2][$];

  logic       ack_v[2];
  logic       err_v[2];
  logic [7:0] rd_v[2];
  logic [3:0] we_v[2];
  logic [7:0] wdo_v[2];

  reg_access_ctrl_if #(.A_WIDTH(8), .W_WIDTH(8)) a_bus ();
  reg_access_ctrl_if #(.A_WIDTH(8), .W_WIDTH(8)) b_bus ();

  assign a_bus.sel_en  = sel_en & ~use_b;
  assign a_bus.wr_rd_s = wr_rd_s;
  assign a_bus.addr    = addr;
  assign a_bus.wr_data = wr_data;
  assign b_bus.sel_en  = sel_en & use_b;
  assign b_bus.wr_rd_s = wr_rd_s;
  assign b_bus.addr    = addr;
  assign b_bus.wr_data = wr_data;

  assign ack_v[0] = a_bus.ack;
  assign err_v[0] = a_bus.err;
  assign rd_v[0]  = a_bus.rd_data;
  assign ack_v[1] = b_bus.ack;
  assign err_v[1] = b_bus.err;
  assign rd_v[1]  = b_bus.rd_data;

  reg_access_ctrl #(
    .NUM_OF_REG (4),
    .W_WIDTH    (8),
    .A_WIDTH    (8),
    .RO_MASK    (4'b1000),
    .WAIT_CYC   (2)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (a_bus),
    .reg_data_in (reg_data),
    .wr_en       (we_v[0]),
    .wr_data_out (wdo_v[0])
  );

  reg_access_ctrl #(
    .NUM_OF_REG (4),
    .W_WIDTH    (8),
    .A_WIDTH    (8),
    .RO_MASK    (4'b1000),
    .WAIT_CYC   (0)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (b_bus),
    .reg_data_in (reg_data),
    .wr_en       (we_v[1]),
    .wr_data_out (wdo_v[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Monitor: every ack pops one expected response; wr_en outside ack and
  // a response that never arrives are both reported.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ack_v[d]) begin
          if (q[d].size() == 0) begin
            chk($sformatf("unexpected_ack_%0d", d), 32'(ack_v[d]), 32'd0);
          end else begin
            exp_t e;
            e = q[d].pop_front();
            chk($sformatf("ack_cycle_%0d", d), ecount, e.edge_n);
            chk($sformatf("wr_en_%0d", d), 32'(we_v[d]), 32'(e.we));
            chk($sformatf("wr_data_out_%0d", d), 32'(wdo_v[d]), 32'(e.wdo));
            chk($sformatf("rd_data_%0d", d), 32'(rd_v[d]), 32'(e.rd));
            chk($sformatf("err_%0d", d), 32'(err_v[d]), 32'(e.err));
          end
        end else begin
          if (we_v[d] != '0) begin
            chk($sformatf("stray_wr_en_%0d", d), 32'(we_v[d]), 32'd0);
          end
          if ((q[d].size() != 0) && (q[d][0].edge_n < ecount)) begin
            chk($sformatf("missing_ack_%0d", d), 32'(ack_v[d]), 32'd1);
            void'(q[d].pop_front());
          end
        end
      end
    end
  end

  // One request, issued on a falling edge. Request fields are scrambled
  // after the first cycle to show they are captured only once.
  task automatic txn(input bit b, input bit wr, input logic [7:0] a,
                     input logic [7:0] d, input int hold, input bit abort,
                     input bit chk_hold, input logic [3:0] e_we,
                     input logic [7:0] e_wdo, input logic [7:0] e_rd,
                     input logic e_err);
    int w;
    int n0;
    w       = b ? 0 : 2;
    use_b   = b;
    wr_rd_s = wr;
    addr    = a;
    wr_data = d;
    sel_en  = 1'b1;
    n0      = ecount + 1;
    if (!abort) q[int'(b)].push_back('{n0 + w, e_we, e_wdo, e_rd, e_err});
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr    = ~a;
        wr_data = ~d;
        wr_rd_s = ~wr;
      end
      if (chk_hold && (ecount > n0 + w)) begin
        chk("hold_rd_data", 32'(rd_v[int'(b)]), 32'(e_rd));
        chk("hold_err", 32'(err_v[int'(b)]), 32'(e_err));
      end
    end
    sel_en = 1'b0;
    @(negedge clk);
    if (chk_hold) begin
      chk("idle_rd_data", 32'(rd_v[int'(b)]), 32'd0);
      chk("idle_err", 32'(err_v[int'(b)]), 32'd0);
    end
  endtask

  initial begin
    int n0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(ack_v[d]), 32'd0);
      chk("reset_wr_en", 32'(we_v[d]), 32'd0);
      chk("reset_rd_data", 32'(rd_v[d]), 32'd0);
      chk("reset_err", 32'(err_v[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // dut 0, two wait states
    txn(0, 1, 8'h02, 8'hA5, 6, 0, 0, 4'b0100, 8'hA5, 8'h00, 1'b0);
    txn(0, 0, 8'h01, 8'h00, 5, 0, 1, 4'b0000, 8'hA5, 8'h3C, 1'b0);
    txn(0, 1, 8'h03, 8'h5A, 4, 0, 0, 4'b0000, 8'hA5, 8'h00, 1'b1);
    txn(0, 0, 8'h04, 8'h00, 5, 0, 1, 4'b0000, 8'hA5, 8'h00, 1'b1);
    txn(0, 0, 8'h84, 8'h00, 4, 0, 0, 4'b0000, 8'hA5, 8'h00, 1'b1);
    txn(0, 0, 8'h03, 8'h00, 4, 0, 0, 4'b0000, 8'hA5, 8'hD4, 1'b0);
    txn(0, 1, 8'h00, 8'hEE, 1, 1, 0, 4'b0000, 8'h00, 8'h00, 1'b0);
    txn(0, 1, 8'h00, 8'h42, 4, 0, 0, 4'b0001, 8'h42, 8'h00, 1'b0);

    // reset while dut 0 sits in HOLD after a write
    use_b   = 1'b0;
    wr_rd_s = 1'b1;
    addr    = 8'h01;
    wr_data = 8'h99;
    sel_en  = 1'b1;
    n0      = ecount + 1;
    q[0].push_back('{n0 + 2, 4'b0010, 8'h99, 8'h00, 1'b0});
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("hold_reset_ack", 32'(ack_v[0]), 32'd0);
    chk("hold_reset_wr_en", 32'(we_v[0]), 32'd0);
    chk("hold_reset_wr_data_out", 32'(wdo_v[0]), 32'd0);
    chk("hold_reset_rd_data", 32'(rd_v[0]), 32'd0);
    chk("hold_reset_err", 32'(err_v[0]), 32'd0);
    sel_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 0, 8'h01, 8'h00, 5, 0, 1, 4'b0000, 8'h00, 8'h3C, 1'b0);

    // dut 1, no wait states, back-to-back with one idle cycle
    txn(1, 1, 8'h01, 8'h12, 1, 0, 0, 4'b0010, 8'h12, 8'h00, 1'b0);
    txn(1, 1, 8'h02, 8'h34, 1, 0, 0, 4'b0100, 8'h34, 8'h00, 1'b0);
    txn(1, 1, 8'h03, 8'h56, 2, 0, 0, 4'b0000, 8'h34, 8'h00, 1'b1);
    txn(1, 0, 8'h00, 8'h00, 3, 0, 1, 4'b0000, 8'h34, 8'h11, 1'b0);

    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pending_responses_%0d", d), 32'(q[d].size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Parametrised register-access controller for the switch configuration path. It sits between the configuration master (sel_en / wr_rd_s / addr handshake) and the switch's bank of per-port registers. It generalises the fixed 4-register, 8-bit access FSM to NUM_OF_REG registers of W_WIDTH bits. New behaviour over that FSM:
- configurable wait states,
- single-pulse acknowledge per transaction,
- error response for out-of-range addresses and for writes to read-only registers.

## Interface
- NUM_OF_REG, 4, number of registers; 1..2**A_WIDTH
- W_WIDTH, 8, register data width
- A_WIDTH, 8, address width; must be ≥ clog2(NUM_OF_REG)
- RO_MASK, 0, NUM_OF_REG-bit mask; bit i = 1 makes register i read-only
- WAIT_CYC, 0, wait states inserted before the response; 0..15
- clk  in  1  clock; all flops on posedge
- rst_n  in  1  asynchronous, active-low reset
- sel_en  in  1  transaction request; held high by the master until ack is seen
- wr_rd_s  in  1  1 = write, 0 = read
- addr  in  A_WIDTH  register index
- wr_data  in  W_WIDTH  write data
- reg_data_in  in  NUM_OF_REG*W_WIDTH  register i occupies bits [i*W_WIDTH +: W_WIDTH]
- wr_en  out  NUM_OF_REG  one-hot write strobe
- wr_data_out  out  W_WIDTH  captured write data, valid with wr_en
- rd_data  out  W_WIDTH  read data
- ack  out  1  single-cycle response pulse
- err  out  1  error flag, valid with ack

## Operation
- FSM states: IDLE, WAIT, RESP, HOLD.
- **IDLE**
  - When sel_en = 1, capture addr, wr_rd_s and wr_data into request registers.
  - Go to RESP if WAIT_CYC = 0; otherwise load the counter with WAIT_CYC and go to WAIT.
- **WAIT**
  - The counter decrements each cycle; go to RESP on the cycle the counter reaches 1.
  - sel_en = 0 while in WAIT aborts the transaction: go to IDLE with no ack and no wr_en.
- **Error decode** (uses the captured request)
  - err_c = (addr ≥ NUM_OF_REG), or (write and RO_MASK[addr]).
  - addr is compared at full A_WIDTH width; it is never truncated.
- **Entering RESP** (all outputs registered)
  - ack ← 1; err ← err_c.
  - Valid write: wr_en[addr] ← 1 and wr_data_out ← captured data.
  - Valid read: rd_data ← reg_data_in slice addr, sampled on this edge.
  - Error: wr_en stays 0 and rd_data ← 0.
- **RESP** lasts exactly one cycle.
  - Go to HOLD if sel_en = 1; go to IDLE if sel_en = 0.
  - ack and wr_en clear on exit.
- **HOLD**
  - Wait for sel_en = 0, then go to IDLE.
  - Exactly one transaction is performed per sel_en assertion. A master holding sel_en high never causes repeated writes.
- Output holding and clearing
  - rd_data and err hold their values through HOLD.
  - rd_data and err clear to 0 on the edge that enters IDLE.
  - wr_data_out holds its last value until the next write.

## Timing
- Reset (asynchronous, immediate): state = IDLE; counter, request registers, wr_en, wr_data_out, rd_data, ack and err all 0.
- Reset during WAIT, RESP or HOLD discards the transaction. A pending wr_en is dropped in the same instant.
- Latency: sel_en first sampled high in cycle 0 → ack and wr_en high in cycle 1+WAIT_CYC, for exactly one cycle.
- Read data reflects reg_data_in during cycle WAIT_CYC.
- Back-to-back transactions need sel_en low for ≥ 1 cycle. Minimum spacing is 2+WAIT_CYC cycles from one sel_en rise to the next sel_en rise.
- Changes to addr, wr_rd_s or wr_data after cycle 0 are ignored.
- sel_en falling in the same cycle as RESP is legal; it goes straight to IDLE.

## Structure
- Package reg_access_pkg holds:
  - state enum: IDLE, WAIT, RESP, HOLD
  - WAIT_CNT_W = 4
  - encoding constants WR = 1 and RD = 0
- Sub-module reg_addr_decode (combinational):
  - inputs: captured addr and wr_rd_s, plus NUM_OF_REG and RO_MASK
  - outputs: one-hot write vector and err_c
- Top level contains the FSM, the wait counter, the request capture registers and the output registers.

## Test plan
Configuration for all scenarios unless stated: NUM_OF_REG = 4, W_WIDTH = 8, RO_MASK = 4'b1000, WAIT_CYC = 2.
- **Write:** write addr = 2, data = 8'hA5, sel_en held 6 cycles → wr_en = 4'b0100 and wr_data_out = A5 in cycle 3 only; ack a 1-cycle pulse in cycle 3; err = 0; no further strobe.
- **Read:** read addr = 1 with reg_data_in slice 1 = 8'h3C → rd_data = 3C from cycle 3 until sel_en drops; err = 0; wr_en = 0 throughout.
- **Errors:**
  - write addr = 3 (read-only) → ack and err in cycle 3, wr_en = 0;
  - read addr = 8'h04 → ack, err = 1, rd_data = 0.
- **Abort:** sel_en dropped in cycle 1 (WAIT) → no ack and no wr_en; the next request completes normally.
- **Reset and zero wait:**
  - rst_n pulsed low during HOLD → all outputs 0 immediately, state IDLE;
  - with WAIT_CYC = 0, a write ack arrives in cycle 1;
  - back-to-back writes with 1 idle cycle between them → two distinct strobes.
